// File: rtl/pattern_gen_mc.sv
// Multi-channel framed pattern generator: a header word carrying the frame count,
// then NUM_CH*FRAME_LEN channel-interleaved samples over a valid/ready handshake.
module pattern_gen_mc #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 256,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] step,
  input  logic [DATA_W-1:0] const_val,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [CH_W-1:0]   ch_id,
  output logic              frame_start,
  output logic [15:0]       frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                         state_reg, state_next;
  logic [CH_W-1:0]                ch_reg, ch_next;
  logic [15:0]                    idx_reg, idx_next;
  logic [15:0]                    fc_reg, fc_next;
  logic [1:0]                     mode_reg, mode_next;
  logic [DATA_W-1:0]              step_reg, step_next;
  logic [DATA_W-1:0]              const_reg, const_next;
  logic [NUM_CH-1:0][DATA_W-1:0]  acc_reg;
  logic [NUM_CH-1:0][DATA_W-1:0]  acc_next;
  logic [DATA_W-1:0]              acc_sel;
  logic                           xfer;
  logic                           acc_step;
  logic                           last_ch;
  logic                           last_idx;

  assign xfer     = data_valid && data_ready;
  assign acc_step = (state_reg == DATA) && xfer;
  assign last_ch  = (ch_reg == CH_W'(NUM_CH - 1));
  assign last_idx = (idx_reg == 16'(FRAME_LEN - 1));

  // Only the channel being transferred advances, and only in the ramp modes.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_acc
    logic hit;
    assign hit = acc_step && (ch_reg == CH_W'(gi)) && !mode_reg[1];
    assign acc_next[gi] = !hit          ? acc_reg[gi] :
                          mode_reg[0]   ? acc_reg[gi] - step_reg :
                                          acc_reg[gi] + step_reg;
  end

  always_comb begin
    acc_sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_reg == CH_W'(c)) acc_sel = acc_reg[c];
    end
  end

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    idx_next   = idx_reg;
    fc_next    = fc_reg;
    mode_next  = mode_reg;
    step_next  = step_reg;
    const_next = const_reg;
    case (state_reg)
      IDLE: begin
        if (enable) state_next = HDR;
      end
      HDR: begin
        if (xfer) begin
          mode_next  = mode;
          step_next  = step;
          const_next = const_val;
          ch_next    = '0;
          idx_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          if (last_ch) begin
            ch_next = '0;
            if (last_idx) begin
              // Frame complete: enable is only consulted here, never mid-frame.
              idx_next   = '0;
              fc_next    = fc_reg + 16'd1;
              state_next = enable ? HDR : IDLE;
            end else begin
              idx_next = idx_reg + 16'd1;
            end
          end else begin
            ch_next = ch_reg + CH_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    data_valid  = 1'b0;
    data_out    = '0;
    ch_id       = '0;
    frame_start = 1'b0;
    frame_count = fc_reg;
    case (state_reg)
      HDR: begin
        data_valid  = 1'b1;
        frame_start = 1'b1;
        data_out    = DATA_W'(fc_reg);
      end
      DATA: begin
        data_valid = 1'b1;
        ch_id      = ch_reg;
        case (mode_reg)
          2'd2:    data_out = const_reg;
          2'd3:    data_out = DATA_W'(idx_reg);
          default: data_out = acc_sel;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      idx_reg   <= '0;
      fc_reg    <= '0;
      mode_reg  <= '0;
      step_reg  <= '0;
      const_reg <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_reg[c] <= DATA_W'(c);
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      idx_reg   <= idx_next;
      fc_reg    <= fc_next;
      mode_reg  <= mode_next;
      step_reg  <= step_next;
      const_reg <= const_next;
      acc_reg   <= acc_next;
    end
  end

endmodule

// File: tb/tb_pattern_gen_mc.sv
// Directed scoreboard bench for pattern_gen_mc (DATA_W=8, NUM_CH=2, FRAME_LEN=4).
module tb_pattern_gen_mc;

  localparam int DW = 8;
  localparam int NC = 2;
  localparam int FL = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic [DW-1:0] step;
  logic [DW-1:0] const_val;
  logic          data_ready;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          ch_id;
  logic          frame_start;
  logic [15:0]   frame_count;

  pattern_gen_mc #(.DATA_W(DW), .NUM_CH(NC), .FRAME_LEN(FL)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .step(step),
    .const_val(const_val), .data_ready(data_ready), .data_out(data_out),
    .data_valid(data_valid), .ch_id(ch_id), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ch;
    logic          fs;
  } word_t;

  word_t         exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] acc_m [NC];
  logic [15:0]   fc_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) acc_m[c] = DW'(c);
    fc_m = 16'd0;
  endtask

  // Reference model: queue the header and every sample of one frame.
  task automatic push_frame(input logic [1:0] m, input logic [DW-1:0] st, input logic [DW-1:0] cv);
    word_t w;
    w.data = fc_m[DW-1:0]; w.ch = 1'b0; w.fs = 1'b1;
    exp_q.push_back(w);
    for (int s = 0; s < FL; s++) begin
      for (int c = 0; c < NC; c++) begin
        w.ch = 1'(c); w.fs = 1'b0;
        case (m)
          2'd0: begin w.data = acc_m[c]; acc_m[c] = acc_m[c] + st; end
          2'd1: begin w.data = acc_m[c]; acc_m[c] = acc_m[c] - st; end
          2'd2: w.data = cv;
          default: w.data = DW'(s);
        endcase
        exp_q.push_back(w);
      end
    end
    fc_m = fc_m + 16'd1;
  endtask

  // One clock: compare at the falling edge, then return just after the rising edge.
  task automatic tick();
    word_t w;
    @(negedge clock);
    if (data_valid === 1'b1 && data_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("data_out", data_out, w.data);
        check("ch_id", ch_id, w.ch);
        check("frame_start", frame_start, w.fs);
      end
    end else if (data_valid === 1'b1 && exp_q.size() != 0) begin
      check("hold_data", data_out, exp_q[0].data);
      check("hold_ch", ch_id, exp_q[0].ch);
      check("hold_fs", frame_start, exp_q[0].fs);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; step = '0; const_val = '0; data_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    check("rst_valid", data_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_ch", ch_id, 0);
    check("rst_fs", frame_start, 0);
    check("rst_fc", frame_count, 0);

    // Ramp up, step 1; enable dropped after the second sample.
    mode = 2'd0; step = 8'd1; data_ready = 1'b1; enable = 1'b1;
    push_frame(2'd0, 8'd1, 8'd0);
    tick();
    check("latency_valid", data_valid, 1);
    tick(); tick(); tick();
    enable = 1'b0;
    drain(30);
    check("f1_idle_valid", data_valid, 0);
    check("f1_fc", frame_count, 1);
    tick();
    check("f1_stay_idle", data_valid, 0);

    // Backpressure for three cycles on the third sample.
    enable = 1'b1;
    push_frame(2'd0, 8'd1, 8'd0);
    tick();
    enable = 1'b0;
    tick(); tick(); tick();
    data_ready = 1'b0;
    repeat (3) tick();
    data_ready = 1'b1;
    drain(30);
    check("f2_fc", frame_count, 2);

    // After reset: ramp 0x80 wraps, then ramp down back-to-back with a mid-frame config change.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("rst2_fc", frame_count, 0);
    mode = 2'd0; step = 8'h80; enable = 1'b1;
    push_frame(2'd0, 8'h80, 8'd0);
    push_frame(2'd1, 8'd1, 8'd0);
    tick();
    tick();
    mode = 2'd1; step = 8'd1;
    for (int i = 0; i < 17; i++) begin
      tick();
      if (i == 8) enable = 1'b0;
      if (i < 16) check("no_bubble", data_valid, 1);
    end
    check("f4_idle_valid", data_valid, 0);
    check("f4_fc", frame_count, 2);
    check("f4_queue", exp_q.size(), 0);

    // Constant, then sample index, then step-0 ramp exposing untouched accumulators.
    mode = 2'd2; const_val = 8'h5A; step = 8'd0; enable = 1'b1;
    push_frame(2'd2, 8'd0, 8'h5A);
    push_frame(2'd3, 8'd0, 8'd0);
    push_frame(2'd0, 8'd0, 8'd0);
    tick(); tick();
    mode = 2'd3; const_val = 8'h00;
    repeat (9) tick();
    mode = 2'd0;
    repeat (9) tick();
    enable = 1'b0;
    drain(30);
    check("f7_fc", frame_count, 5);

    // Reset mid-frame while stalled.
    mode = 2'd0; step = 8'd1; enable = 1'b1;
    push_frame(2'd0, 8'd1, 8'd0);
    tick();
    enable = 1'b0;
    tick(); tick(); tick();
    data_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    model_reset();
    check("midrst_valid", data_valid, 0);
    check("midrst_fc", frame_count, 0);
    check("midrst_data", data_out, 0);
    check("midrst_fs", frame_start, 0);
    data_ready = 1'b1; enable = 1'b1;
    push_frame(2'd0, 8'd1, 8'd0);
    tick();
    enable = 1'b0;
    drain(30);
    check("final_fc", frame_count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_gen_mc.md
PATTERN_GEN_MC -- requirements
Module: pattern_gen_mc

Interface
REQ-001 Parameter DATA_W, default 16: sample and header word width in bits.
REQ-002 Parameter NUM_CH, default 4: channel count, 1..16.
REQ-003 Parameter FRAME_LEN, default 256: samples per channel per frame, 1..65535.
REQ-004 Port clock, input, 1: single clock; all logic rising-edge.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port enable, input, 1: run request.
REQ-007 Port mode, input, 2: 0 ramp up, 1 ramp down, 2 constant, 3 sample index.
REQ-008 Port step, input, DATA_W: ramp increment.
REQ-009 Port const_val, input, DATA_W: constant-mode value.
REQ-010 Port data_ready, input, 1: downstream accepts the word when high.
REQ-011 Port data_out, output, DATA_W: header or sample word.
REQ-012 Port data_valid, output, 1: data_out is valid.
REQ-013 Port ch_id, output, max(1,clog2(NUM_CH)): channel of the current sample; 0 during the header.
REQ-014 Port frame_start, output, 1: high only while the header word is presented.
REQ-015 Port frame_count, output, 16: completed-frame count.

Function
REQ-016 The block SHALL implement the states IDLE, HDR and DATA.
REQ-017 A transfer SHALL occur only in a cycle where data_valid=1 and data_ready=1.
REQ-018 IDLE: data_valid=0; if enable=1, the block SHALL move to HDR on the next cycle.
REQ-019 data_valid SHALL be 1 in HDR and DATA.
REQ-020 HDR: data_out SHALL be frame_count zero-extended or truncated to DATA_W; ch_id=0; frame_start=1.
REQ-021 On the HDR transfer, the block SHALL latch mode, step and const_val for the whole frame and enter DATA.
REQ-022 DATA SHALL emit NUM_CH*FRAME_LEN words, channel-interleaved: sample 0 for ch0..chNUM_CH-1, then sample 1, and so on.
REQ-023 Each channel c SHALL hold a DATA_W accumulator acc[c]; on reset acc[c]=c mod 2^DATA_W.
REQ-024 Mode 0 SHALL output acc[c] and, on its transfer, set acc[c]=acc[c]+step mod 2^DATA_W.
REQ-025 Mode 1 SHALL output acc[c] and, on its transfer, set acc[c]=acc[c]-step mod 2^DATA_W.
REQ-026 Mode 2 SHALL output the latched const_val; acc[c] unchanged.
REQ-027 Mode 3 SHALL output the sample index (0..FRAME_LEN-1) truncated to DATA_W; acc[c] unchanged.
REQ-028 Accumulators SHALL persist across frames; they are cleared only by reset.
REQ-029 While data_valid=1 and data_ready=0, data_out, ch_id, frame_start and state SHALL hold stable.
REQ-030 On the last DATA transfer, frame_count SHALL increment, wrapping 0xFFFF->0.
REQ-031 After the last DATA transfer, the next state SHALL be HDR if enable=1 in that cycle, else IDLE.
REQ-032 Deasserting enable mid-frame SHALL NOT truncate the frame.
REQ-033 Mode/step/const_val changes mid-frame SHALL take effect only at the next HDR transfer.
REQ-034 Latency: enable=1 in IDLE -> data_valid=1 on the following cycle.
REQ-035 Latency: back-to-back words with data_ready held high -> one word per cycle, no bubbles, including across frames.

Reset
REQ-036 With reset=1 at a clock edge: state=IDLE, data_valid=0, data_out=0, ch_id=0, frame_start=0, frame_count=0, acc[c]=c, latched mode/step/const_val=0.
REQ-037 Reset SHALL take priority over all other inputs, including mid-frame and during backpressure.

Verification (DATA_W=8, NUM_CH=2, FRAME_LEN=4)
REQ-038 Reset, then enable=1, mode=0, step=1, ready=1 -> words 0x00 (frame_start=1), then 0,1,1,2,2,3,3,4 with ch_id alternating 0,1; frame_count=1 afterwards.
REQ-039 As REQ-038, ready=0 for 3 cycles while the 3rd sample is presented -> word 1/ch0 held stable; no loss or duplication.
REQ-040 mode=0, step=0x80 -> ch1 samples 0x01,0x81,0x01,0x81 (wrap).
REQ-041 mode=1, step=1 -> ch0 samples 0x00,0xFF,0xFE,0xFD.
REQ-042 enable dropped after the 2nd sample -> remaining 6 samples are still emitted; then IDLE with data_valid=0 and frame_count=1.
REQ-043 reset pulsed mid-frame during backpressure -> next cycle data_valid=0 and frame_count=0; re-enable -> header 0x00 and ch0 first sample 0.
